camac_cycle_sequencer: RTL and testbench

Sequences single CAMAC dataway cycles for the Messbauer CAMAC controller. It takes one command at a time from the serial command decoder: an addressed NAF cycle, a Z (initialise), a C (clear), or an inhibit level change. It drives N/F/A/W, B, S1, S2, Z, C and I with programmable phase timing, samples R/X/Q, and returns one response per command. All bus outputs are active-high logic levels; backplane inversion is done outside this block.

---
 rtl/camac_pkg.sv | 48 ++++
 rtl/camac_cycle_sequencer_timer.sv | 26 ++
 rtl/camac_cycle_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_camac_cycle_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/camac_pkg.sv
// Shared encodings and timing defaults for the CAMAC cycle sequencer.
// Optional retry-on-no-X build is selected by the CAMAC_XRETRY_EN macro.
package camac_pkg;

   typedef enum logic [1:0] {
      K_NAF = 2'd0,
      K_Z   = 2'd1,
      K_C   = 2'd2,
      K_INH = 2'd3
   } kind_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_S1,
      S_GAP,
      S_S2,
      S_HOLD,
      S_DONE
   } state_e;

   localparam int T_SETUP_DEF = 10;
   localparam int T_S1_DEF    = 10;
   localparam int T_GAP_DEF   = 10;
   localparam int T_S2_DEF    = 10;
   localparam int T_HOLD_DEF  = 10;
   localparam int N_MAX_DEF   = 24;
   localparam int XRETRY_MAX  = 3;

   localparam logic [4:0] F_READ_LO  = 5'd0;
   localparam logic [4:0] F_READ_HI  = 5'd7;
   localparam logic [4:0] F_WRITE_LO = 5'd16;
   localparam logic [4:0] F_WRITE_HI = 5'd23;

   function automatic logic is_read(input logic [4:0] f);
      return (f >= F_READ_LO) && (f <= F_READ_HI);
   endfunction

   function automatic logic is_write(input logic [4:0] f);
      return (f >= F_WRITE_LO) && (f <= F_WRITE_HI);
   endfunction

   // Phase counter reload value: a phase of t clocks counts t-1 down to 0.
   function automatic logic [7:0] ld(input int t);
      return 8'(t - 1);
   endfunction

endpackage

// File: rtl/camac_cycle_sequencer_timer.sv
// Phase duration counter: load, count down, flag terminal count.
// Shared by every timed phase of the sequencer.
module camac_phase_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       tc
);

   logic [7:0] cnt;

   // Reload on phase entry, otherwise count down and stop at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 8'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != 8'd0) begin
         cnt <= cnt - 8'd1;
      end
   end

   assign tc = (cnt == 8'd0);

endmodule

// File: rtl/camac_cycle_sequencer.sv
// Runs one CAMAC dataway cycle (NAF, Z, C or inhibit change) per command.
// Optional macro CAMAC_XRETRY_EN repeats a NAF cycle that saw X=0.
module camac_cycle_sequencer
   import camac_pkg::*;
#(
   parameter int T_SETUP = T_SETUP_DEF,
   parameter int T_S1    = T_S1_DEF,
   parameter int T_GAP   = T_GAP_DEF,
   parameter int T_S2    = T_S2_DEF,
   parameter int T_HOLD  = T_HOLD_DEF,
   parameter int N_MAX   = N_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_kind,
   input  logic [5:0]  cmd_n,
   input  logic [4:0]  cmd_f,
   input  logic [3:0]  cmd_a,
   input  logic [23:0] cmd_w,
   output logic        rsp_valid,
   output logic [23:0] rsp_r,
   output logic        rsp_x,
   output logic        rsp_q,
`ifdef CAMAC_XRETRY_EN
   output logic [1:0]  rsp_retries,
`endif
   output logic        rsp_err,
   output logic [5:0]  camac_n,
   output logic [4:0]  camac_f,
   output logic [3:0]  camac_a,
   output logic [23:0] camac_w,
   input  logic [23:0] camac_r,
   input  logic        camac_x,
   input  logic        camac_q,
   output logic        camac_b,
   output logic        camac_s1,
   output logic        camac_s2,
   output logic        camac_z,
   output logic        camac_c,
   output logic        camac_i
);

   localparam logic [5:0] N_MAX_V = 6'(N_MAX);

   state_e      state;
   kind_e       kind_q;
   kind_e       kind_in;
   logic        inh;
   logic [23:0] samp_r;
   logic        samp_x;
   logic        samp_q;
   logic        accept;
   logic        n_ok;
   logic        go_bus;
   logic        retry;
   logic        tm_load;
   logic [7:0]  tm_val;
   logic        tc;
`ifdef CAMAC_XRETRY_EN
   logic [1:0]  retry_cnt;
`endif

   assign kind_in = kind_e'(cmd_kind);
   assign accept  = cmd_valid & cmd_ready;
   assign n_ok    = (cmd_n != 6'd0) && (cmd_n <= N_MAX_V);
   assign go_bus  = ((kind_in == K_NAF) && n_ok) ||
                    (kind_in == K_Z) || (kind_in == K_C);

`ifdef CAMAC_XRETRY_EN
   assign retry = (kind_q == K_NAF) && !samp_x &&
                  (retry_cnt != 2'(XRETRY_MAX));
`else
   assign retry = 1'b0;
`endif

   camac_phase_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tm_load),
      .load_val (tm_val),
      .tc       (tc)
   );

   // Reload the phase timer with the length of the phase being entered.
   always_comb begin
      tm_load = 1'b0;
      tm_val  = 8'd0;
      unique case (state)
         S_IDLE:  if (accept && go_bus) begin
                     tm_load = 1'b1;
                     tm_val  = ld(T_SETUP);
                  end
         S_SETUP: if (tc) begin
                     tm_load = 1'b1;
                     tm_val  = ld(T_S1);
                  end
         S_S1:    if (tc) begin
                     tm_load = 1'b1;
                     tm_val  = ld(T_GAP);
                  end
         S_GAP:   if (tc) begin
                     tm_load = 1'b1;
                     tm_val  = ld(T_S2);
                  end
         S_S2:    if (tc) begin
                     tm_load = 1'b1;
                     tm_val  = ld(T_HOLD);
                  end
         S_HOLD:  if (tc && retry) begin
                     tm_load = 1'b1;
                     tm_val  = ld(T_SETUP);
                  end
         default: ;
      endcase
   end

   // Cycle FSM; every bus and response output is registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         kind_q    <= K_NAF;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_r     <= 24'd0;
         rsp_x     <= 1'b0;
         rsp_q     <= 1'b0;
         rsp_err   <= 1'b0;
         camac_n   <= 6'd0;
         camac_f   <= 5'd0;
         camac_a   <= 4'd0;
         camac_w   <= 24'd0;
         camac_b   <= 1'b0;
         camac_s1  <= 1'b0;
         camac_s2  <= 1'b0;
         camac_z   <= 1'b0;
         camac_c   <= 1'b0;
         camac_i   <= 1'b0;
         inh       <= 1'b0;
         samp_r    <= 24'd0;
         samp_x    <= 1'b0;
         samp_q    <= 1'b0;
`ifdef CAMAC_XRETRY_EN
         retry_cnt   <= 2'd0;
         rsp_retries <= 2'd0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (accept) begin
                  cmd_ready <= 1'b0;
                  kind_q    <= kind_in;
                  samp_r    <= 24'd0;
                  samp_x    <= 1'b0;
                  samp_q    <= 1'b0;
`ifdef CAMAC_XRETRY_EN
                  retry_cnt <= 2'd0;
`endif
                  if (go_bus) begin
                     state   <= S_SETUP;
                     camac_b <= 1'b1;
                     camac_z <= (kind_in == K_Z);
                     camac_c <= (kind_in == K_C);
                     if (kind_in == K_Z) camac_i <= 1'b1;
                     if (kind_in == K_NAF) begin
                        camac_n <= cmd_n;
                        camac_f <= cmd_f;
                        camac_a <= cmd_a;
                        camac_w <= is_write(cmd_f) ? cmd_w : 24'd0;
                     end
                  end else begin
                     state     <= S_DONE;
                     rsp_valid <= 1'b1;
                     rsp_r     <= 24'd0;
                     rsp_x     <= 1'b0;
                     rsp_q     <= 1'b0;
                     rsp_err   <= (kind_in == K_NAF);
`ifdef CAMAC_XRETRY_EN
                     rsp_retries <= 2'd0;
`endif
                     if (kind_in == K_INH) begin
                        inh     <= cmd_w[0];
                        camac_i <= cmd_w[0];
                     end
                  end
               end
            end
            S_SETUP: if (tc) begin
               state    <= S_S1;
               camac_s1 <= (kind_q == K_NAF);
            end
            S_S1: if (tc) begin
               state    <= S_GAP;
               camac_s1 <= 1'b0;
               if (kind_q == K_NAF) begin
                  samp_x <= camac_x;
                  samp_q <= camac_q;
                  samp_r <= is_read(camac_f) ? camac_r : 24'd0;
               end
            end
            S_GAP: if (tc) begin
               state    <= S_S2;
               camac_s2 <= 1'b1;
            end
            S_S2: if (tc) begin
               state    <= S_HOLD;
               camac_s2 <= 1'b0;
            end
            S_HOLD: if (tc) begin
               if (retry) begin
                  state <= S_SETUP;
`ifdef CAMAC_XRETRY_EN
                  retry_cnt <= retry_cnt + 2'd1;
`endif
               end else begin
                  state     <= S_DONE;
                  camac_n   <= 6'd0;
                  camac_f   <= 5'd0;
                  camac_a   <= 4'd0;
                  camac_w   <= 24'd0;
                  camac_b   <= 1'b0;
                  camac_z   <= 1'b0;
                  camac_c   <= 1'b0;
                  camac_i   <= inh;
                  rsp_valid <= 1'b1;
                  rsp_r     <= samp_r;
                  rsp_x     <= samp_x;
                  rsp_q     <= samp_q;
                  rsp_err   <= 1'b0;
`ifdef CAMAC_XRETRY_EN
                  rsp_retries <= retry_cnt;
`endif
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_camac_cycle_sequencer.sv
// Scoreboard bench for camac_cycle_sequencer: directed commands,
// per-cycle bus timing checks and a decoupled response monitor.
module tb_camac_cycle_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_kind = 2'd0;
   logic [5:0]  cmd_n = 6'd0;
   logic [4:0]  cmd_f = 5'd0;
   logic [3:0]  cmd_a = 4'd0;
   logic [23:0] cmd_w = 24'd0;
   logic        rsp_valid;
   logic [23:0] rsp_r;
   logic        rsp_x;
   logic        rsp_q;
   logic        rsp_err;
   logic [5:0]  camac_n;
   logic [4:0]  camac_f;
   logic [3:0]  camac_a;
   logic [23:0] camac_w;
   logic [23:0] camac_r = 24'd0;
   logic        camac_x = 1'b0;
   logic        camac_q = 1'b0;
   logic        camac_b;
   logic        camac_s1;
   logic        camac_s2;
   logic        camac_z;
   logic        camac_c;
   logic        camac_i;

   camac_cycle_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_kind  (cmd_kind),
      .cmd_n     (cmd_n),
      .cmd_f     (cmd_f),
      .cmd_a     (cmd_a),
      .cmd_w     (cmd_w),
      .rsp_valid (rsp_valid),
      .rsp_r     (rsp_r),
      .rsp_x     (rsp_x),
      .rsp_q     (rsp_q),
      .rsp_err   (rsp_err),
      .camac_n   (camac_n),
      .camac_f   (camac_f),
      .camac_a   (camac_a),
      .camac_w   (camac_w),
      .camac_r   (camac_r),
      .camac_x   (camac_x),
      .camac_q   (camac_q),
      .camac_b   (camac_b),
      .camac_s1  (camac_s1),
      .camac_s2  (camac_s2),
      .camac_z   (camac_z),
      .camac_c   (camac_c),
      .camac_i   (camac_i)
   );

   always #10 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [23:0] r;
      logic        x;
      logic        q;
      logic        err;
   } rsp_t;

   rsp_t sb[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   logic inh_model = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name,
                               input logic [127:0] act,
                               input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [127:0] all_out();
      return {cmd_ready, rsp_valid, rsp_r, rsp_x, rsp_q, rsp_err,
              camac_n, camac_f, camac_a, camac_w, camac_b,
              camac_s1, camac_s2, camac_z, camac_c, camac_i};
   endfunction

   // Response monitor: pop the oldest expectation on every rsp_valid.
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_r", rsp_r, e.r);
            chk("rsp_xqe", {rsp_x, rsp_q, rsp_err},
                {e.x, e.q, e.err});
         end
      end
   end

   task automatic run_cmd(input logic [1:0]  kind,
                          input logic [5:0]  n,
                          input logic [4:0]  f,
                          input logic [3:0]  a,
                          input logic [23:0] w,
                          input logic        xi,
                          input logic        qi,
                          input int          rst_at);
      logic legal;
      logic bus;
      int   lat;
      bit   rdy;
      rsp_t e;
      legal = (kind != 2'd0) || (n != 6'd0 && n <= 6'd24);
      lat   = (kind == 2'd3 || !legal) ? 1 : 51;
      rdy   = 0;
      for (int t = 0; t < 20 && !rdy; t++) begin
         @(negedge clk);
         rdy = cmd_ready;
      end
      chk("ready_wait", rdy, 1);
      if (!rdy) return;
      cmd_valid = 1'b1;
      cmd_kind  = kind;
      cmd_n     = n;
      cmd_f     = f;
      cmd_a     = a;
      cmd_w     = w;
      e.cyc = cyc + lat;
      e.r   = (kind == 2'd0 && legal && f <= 5'd7) ? 24'hABCDEF : 24'd0;
      e.x   = (kind == 2'd0 && legal) ? xi : 1'b0;
      e.q   = (kind == 2'd0 && legal) ? qi : 1'b0;
      e.err = (kind == 2'd0) && !legal;
      sb.push_back(e);
      if (kind == 2'd3) inh_model = w[0];
      for (int j = 1; j <= lat + 1; j++) begin
         @(negedge clk);
         if (j == rst_at) begin
            rst_n     = 1'b0;
            cmd_valid = 1'b0;
            #1;
            chk("reset_mid_all_zero", all_out(), 0);
            void'(sb.pop_back());
            inh_model = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("reset_mid_ready", cmd_ready, 1);
            repeat (3) begin
               @(negedge clk);
               chk("reset_mid_no_rsp", {rsp_valid, camac_b, camac_i}, 0);
            end
            return;
         end
         bus = (lat == 51) && (j <= 50);
         chk($sformatf("ctl j=%0d", j),
             {cmd_ready, camac_b, camac_s1, camac_s2,
              camac_z, camac_c, camac_i},
             {(j > lat), bus,
              bus && kind == 2'd0 && j >= 11 && j <= 20,
              bus && j >= 31 && j <= 40,
              bus && kind == 2'd1,
              bus && kind == 2'd2,
              (bus && kind == 2'd1) ? 1'b1 : inh_model});
         chk($sformatf("naf j=%0d", j), {camac_n, camac_f, camac_a},
             (bus && kind == 2'd0) ? {n, f, a} : 15'd0);
         chk($sformatf("w j=%0d", j), camac_w,
             (bus && kind == 2'd0 && f >= 5'd16 && f <= 5'd23) ?
             w : 24'd0);
         if (j == lat + 1) chk("rsp_hold", rsp_r, e.r);
         camac_x   = (j == 20) ? xi : ~xi;
         camac_q   = (j == 20) ? qi : ~qi;
         camac_r   = (j == 20) ? 24'hABCDEF : 24'h5A5A5A;
         cmd_valid = (j <= lat);
         cmd_kind  = 2'd3;
         cmd_w     = {23'd0, ~inh_model};
      end
      cmd_valid = 1'b0;
   endtask

   initial begin
      #3;
      chk("reset_all_zero", all_out(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", cmd_ready, 1);
      run_cmd(2'd0, 6'd5,  5'd0,  4'd2,  24'h000000, 1'b1, 1'b1, 0);
      run_cmd(2'd0, 6'd3,  5'd16, 4'd0,  24'h123456, 1'b1, 1'b0, 0);
      run_cmd(2'd1, 6'd0,  5'd0,  4'd0,  24'h000000, 1'b1, 1'b1, 0);
      run_cmd(2'd3, 6'd0,  5'd0,  4'd0,  24'h000001, 1'b0, 1'b0, 0);
      run_cmd(2'd2, 6'd0,  5'd0,  4'd0,  24'h000000, 1'b1, 1'b1, 0);
      run_cmd(2'd0, 6'd0,  5'd0,  4'd1,  24'h000000, 1'b1, 1'b1, 0);
      run_cmd(2'd0, 6'd25, 5'd0,  4'd1,  24'h000000, 1'b1, 1'b1, 0);
      run_cmd(2'd0, 6'd24, 5'd7,  4'd15, 24'h000000, 1'b0, 1'b1, 0);
      run_cmd(2'd0, 6'd2,  5'd17, 4'd3,  24'h654321, 1'b1, 1'b1, 35);
      run_cmd(2'd0, 6'd1,  5'd23, 4'd4,  24'hFFFFFF, 1'b1, 1'b0, 0);
      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
